pe_result_drain: RTL

PE_RESULT_DRAIN -- requirements
Module: pe_result_drain

---
 rtl/pe_result_drain_pkg.sv | 19 +
 rtl/pe_result_drain.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pe_result_drain_pkg.sv
// Shared PE-array definitions: default array geometry and the result-drain FSM state encoding.
package pe_result_drain_pkg;

  localparam int unsigned PE_NUM_ROWS = 4;
  localparam int unsigned PE_NUM_COLS = 32;
  localparam int unsigned PE_RES_W    = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REARM = 2'd2
  } drain_state_e;

  // Column counter width; a single-column array still needs one bit.
  function automatic int unsigned col_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_result_drain.sv
// Captures a finished PE-array tile into a local buffer and streams it out one column per beat.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for every PE done bit; captures the tile on all_done
//   ST_DRAIN | presenting buffered columns 0..NUM_COLS-1 on a valid/ready port
//   ST_REARM | tile drained; waiting for all_done to drop before accepting more
module pe_result_drain
  import pe_result_drain_pkg::*;
#(
  parameter int unsigned NUM_ROWS = PE_NUM_ROWS,
  parameter int unsigned NUM_COLS = PE_NUM_COLS,
  parameter int unsigned RES_W    = PE_RES_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_ROWS*NUM_COLS*RES_W-1:0]  result,
  input  logic [NUM_ROWS*NUM_COLS-1:0]        done,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_ROWS*RES_W-1:0]           out_data,
  output logic [col_w(NUM_COLS)-1:0]          out_col,
  output logic                                out_last,
  output logic                                busy,
  output logic                                overrun
);

  localparam int unsigned       COL_W    = col_w(NUM_COLS);
  localparam int unsigned       BEAT_W   = NUM_ROWS * RES_W;
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(NUM_COLS - 1);

  drain_state_e      r_state;
  logic [COL_W-1:0]  r_col;
  logic              r_all_done_q;
  logic              r_out_valid;
  logic              r_out_last;
  logic [COL_W-1:0]  r_out_col;
  logic [BEAT_W-1:0] r_out_data;
  logic              r_busy;
  logic              r_overrun;
  logic [BEAT_W-1:0] r_buf [NUM_COLS];

  logic              w_all_done;
  logic              w_handshake;
  logic              w_capture;
  logic [COL_W-1:0]  w_col_nxt;
  logic [BEAT_W-1:0] w_res_cols [NUM_COLS];

  assign w_all_done  = &done;
  assign w_handshake = r_out_valid & out_ready;
  assign w_capture   = (r_state == ST_IDLE) & w_all_done;
  assign w_col_nxt   = r_col + 1'b1;

  // Regroup the row-major PE result bus into column-sized beats.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      assign w_res_cols[c][r*RES_W +: RES_W] = result[(r*NUM_COLS + c)*RES_W +: RES_W];
    end
  end

  // Buffer is frozen outside the capture edge, so upstream may reuse result immediately.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        r_buf[c] <= w_res_cols[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_all_done_q <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_col    <= '0;
      r_out_data   <= '0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_all_done_q <= w_all_done;

      // A fresh all-done while still draining means upstream ignored busy.
      if ((r_state == ST_DRAIN) && w_all_done && !r_all_done_q) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_all_done) begin
            r_state     <= ST_DRAIN;
            r_col       <= '0;
            r_out_valid <= 1'b1;
            r_out_col   <= '0;
            r_out_data  <= w_res_cols[0];
            r_out_last  <= (NUM_COLS == 1);
            r_busy      <= 1'b1;
          end
        end

        ST_DRAIN: begin
          if (w_handshake) begin
            if (r_col == LAST_COL) begin
              r_state     <= ST_REARM;
              r_col       <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_col   <= '0;
            end else begin
              r_col       <= w_col_nxt;
              r_out_col   <= w_col_nxt;
              r_out_data  <= r_buf[w_col_nxt];
              r_out_last  <= (w_col_nxt == LAST_COL);
            end
          end
        end

        ST_REARM: begin
          if (!w_all_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_col   = r_out_col;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule
